hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the EX-stage operand forwarding selects (`Mux_3to1_32bits` encoding) and the PC/IF-ID write enables. It also inserts ID/EX bubbles on load-use hazards and flushes on taken branches. It keeps a registered shadow of each in-flight instruction's destination and register-write/load flags, so the datapath only supplies ID-stage decode fields.

## Interface
Parameters:
- `CNT_W`, 16, width of saturating stall-cycle counter

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID stage holds a real instruction
- `id_rs`, `id_rt`  in  5 each  ID source register numbers
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction actually reads rs / rt
- `id_dst`  in  5  resolved destination (rd/rt/31)
- `id_reg_write`  in  1  instruction writes register file
- `id_mem_read`  in  1  instruction is a load
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX
- `mem_stall`  in  1  data memory not ready; freeze whole pipe
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  EX operand A/B mux select: 0 ID/EX reg value, 1 MEM/WB result, 2 EX/MEM ALU result
- `pc_write`  out  1  PC update enable
- `ifid_write`  out  1  IF/ID register enable
- `idex_bubble`  out  1  load NOP into ID/EX
- `ifid_flush`, `idex_flush`  out  1 each  clear IF/ID, ID/EX
- `stall_cnt`  out  CNT_W  total stall cycles (load-use + freeze), saturating

## Operation
- Shadow stages EX, MEM, WB each hold {rs, rt (EX only), dst, wr, load}. They advance on every clock edge unless frozen. EX captures ID fields gated by `id_valid`. A bubble or flush loads EX with wr=0, load=0, rs=rt=0.
- Forwarding per operand (EX rs for A, EX rt for B):
  - select 2 if MEM.wr && MEM.dst==src && src!=0;
  - else select 1 if WB.wr && WB.dst==src && src!=0;
  - else select 0.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Load-use hazard: `lu = id_valid && EX.load && EX.dst!=0 && ((id_uses_rs && id_rs==EX.dst) || (id_uses_rt && id_rt==EX.dst))`.
- FSM states:
  - RUN: default.
  - LU_STALL: one cycle. `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Then returns to RUN. The load has moved to MEM, so the hazard is cleared and forwarding select 2 is no longer usable for a load; the value arrives via select 1 next cycle.
  - FREEZE: entered while `mem_stall`=1. `pc_write`=`ifid_write`=0, no bubble, shadow holds. Exits to RUN when `mem_stall` falls.
- Priority: `mem_stall` > `ex_branch_taken` > lu.
- Branch taken (not frozen): `ifid_flush`=`idex_flush`=1 and `pc_write`=1. A load-use detected in the same cycle is ignored (the ID instruction is squashed). No transition to LU_STALL.
- `stall_cnt` increments on each cycle in LU_STALL or FREEZE and saturates at all-ones.

## Timing
- Reset (async assert, sync deassert via `clk`):
  - all shadow fields 0; state RUN; `stall_cnt`=0;
  - outputs: fwd selects 0, `pc_write`=1, `ifid_write`=1, bubble/flush 0.
- Forward selects, write enables, bubble and flush are combinational from shadow/state/ID inputs, valid in the same cycle. Shadow and state update at the rising edge.
- Load-use costs exactly 1 stall cycle. Branch costs 2 squashed slots. No extra stall.
- Reset asserted mid-stall or mid-freeze returns to RUN immediately. Pending hazards are discarded.
- `mem_stall` raised during LU_STALL: go to FREEZE. The bubble is not re-issued. After freeze, re-evaluate lu.

## Structure
- Package `mips_hazard_pkg`:
  - `fwd_sel_e` (FWD_REG=2'd0, FWD_WB=2'd1, FWD_MEM=2'd2);
  - `hz_state_e` (RUN, LU_STALL, FREEZE);
  - packed struct `shadow_t` {rs, rt, dst, wr, load}.
- Sub-module `fwd_select`: compares one source against the MEM/WB shadow and returns `fwd_sel_e`. Instantiated twice (A, B).

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → next cycle `fwd_a_sel`=2; one cycle later, with an intervening NOP, `fwd_a_sel`=1.
- `lw $8,0($9)` then `add $10,$8,$8` → one cycle `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; add then in EX with `fwd_a_sel`=`fwd_b_sel`=1; `stall_cnt`=1.
- Writes to `$0` in EX and MEM, consumer reads `$0` → both selects stay 0.
- `ex_branch_taken`=1 with a simultaneous load-use in ID → both flushes 1, `pc_write`=1, no LU_STALL, `stall_cnt` unchanged.
- `mem_stall` high 3 cycles during an EX/MEM dependency → select 2 held constant, `pc_write`=0 for 3 cycles, `stall_cnt`=3.
- `rst_n` pulsed low during LU_STALL → outputs return to reset values asynchronously; state RUN.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared types for the pipeline hazard/forwarding controller
package mips_hazard_pkg;
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;
  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    FREEZE
  } hz_state_e;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       wr;
    logic       load;
  } shadow_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the EX operand source for one register against MEM/WB shadows
module fwd_select
  import mips_hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_dst,
  input  logic       mem_wr,
  input  logic [4:0] wb_dst,
  input  logic       wb_wr,
  output fwd_sel_e   sel
);
  // youngest producer wins; $0 is hardwired and never forwarded
  always_comb
    sel = (src == 5'd0) ? FWD_REG :
          (mem_wr && mem_dst == src) ? FWD_MEM :
          (wb_wr && wb_dst == src) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding selects, load-use stalls, branch flushes and memory freeze
module hazard_fwd_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt
);
  shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu, lu_stall, flush;
  logic             unused_shadow;
  fwd_sel_e         sel_a, sel_b;

  fwd_select u_fwd_a (
    .src(ex_q.rs), .mem_dst(mem_q.dst), .mem_wr(mem_q.wr),
    .wb_dst(wb_q.dst), .wb_wr(wb_q.wr), .sel(sel_a)
  );
  fwd_select u_fwd_b (
    .src(ex_q.rt), .mem_dst(mem_q.dst), .mem_wr(mem_q.wr),
    .wb_dst(wb_q.dst), .wb_wr(wb_q.wr), .sel(sel_b)
  );

  // control: freeze beats branch beats load-use; a load-use stall is never repeated back to back
  always_comb begin
    lu = id_valid && ex_q.load && ex_q.dst != 5'd0 &&
         ((id_uses_rs && id_rs == ex_q.dst) || (id_uses_rt && id_rt == ex_q.dst));
    flush = !mem_stall && ex_branch_taken;
    lu_stall = !mem_stall && !ex_branch_taken && lu && state_q != LU_STALL;
    state_d = mem_stall ? FREEZE : lu_stall ? LU_STALL : RUN;
    pc_write = !(mem_stall || lu_stall);
    ifid_write = !(mem_stall || lu_stall);
    idex_bubble = lu_stall;
    ifid_flush = flush;
    idex_flush = flush;
    fwd_a_sel = sel_a;
    fwd_b_sel = sel_b;
    stall_cnt = stall_cnt_q;
    stall_cnt_d = ((mem_stall || lu_stall) && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  // shadow pipeline: hold on freeze, insert an empty slot on bubble, flush or invalid ID
  always_comb begin
    ex_d = '0;
    if (mem_stall)
      ex_d = ex_q;
    else if (id_valid && !lu_stall && !flush)
      ex_d = shadow_t'{rs: id_rs, rt: id_rt, dst: id_dst, wr: id_reg_write, load: id_mem_read};
    mem_d = mem_stall ? mem_q : ex_q;
    wb_d = mem_stall ? wb_q : mem_q;
  end

  // source and load fields ride along in later stages but only EX consumes them
  always_comb unused_shadow = ^{mem_q.rs, mem_q.rt, mem_q.load, wb_q.rs, wb_q.rt, wb_q.load};

  // state, shadow and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      state_q <= RUN;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: table-driven cycle vectors plus reset and saturation sequences
module tb_hazard_fwd_ctrl;
  localparam int CW = 3;
  localparam int NV = 39;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    ins_t       i;
    logic [1:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] fl;
    int         cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dst;
  logic ex_branch_taken, mem_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
  logic [CW-1:0] stall_cnt;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl [NV];
  ins_t NOP, ADD3, SUB4, A7, B7, C9, D0, E0, F5, LW8, ADD10, ADDI8, GHOST;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stall_cnt(stall_cnt)
  );

  function automatic ins_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
    mk = '{v: 1'b1, rs: rs, rt: rt, urs: urs, urt: urt, dst: dst, rw: rw, mr: mr};
  endfunction

  function automatic vec_t row(input ins_t i, input logic [1:0] ctl, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [3:0] fl, input int cnt);
    row.i = i;
    row.ctl = ctl;
    row.fa = fa;
    row.fb = fb;
    row.fl = fl;
    row.cnt = cnt;
  endfunction

  task automatic drive(input ins_t i, input logic br, input logic ms);
    id_valid = i.v;
    id_rs = i.rs;
    id_rt = i.rt;
    id_uses_rs = i.urs;
    id_uses_rt = i.urt;
    id_dst = i.dst;
    id_reg_write = i.rw;
    id_mem_read = i.mr;
    ex_branch_taken = br;
    mem_stall = ms;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // fl = {pc_write, ifid_write, idex_bubble, both flushes}
  task automatic check_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [3:0] fl, input int cnt);
    chk({tag, " fwd_a_sel"}, fwd_a_sel, fa);
    chk({tag, " fwd_b_sel"}, fwd_b_sel, fb);
    chk({tag, " pc_write"}, pc_write, fl[3]);
    chk({tag, " ifid_write"}, ifid_write, fl[2]);
    chk({tag, " idex_bubble"}, idex_bubble, fl[1]);
    chk({tag, " ifid_flush"}, ifid_flush, fl[0]);
    chk({tag, " idex_flush"}, idex_flush, fl[0]);
    chk({tag, " stall_cnt"}, stall_cnt, cnt);
  endtask

  initial begin
    NOP = '0;
    ADD3 = mk(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    SUB4 = mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    A7 = mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    B7 = mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    C9 = mk(5'd4, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    D0 = mk(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    E0 = mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    F5 = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    LW8 = mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    ADD10 = mk(5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    ADDI8 = mk(5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    GHOST = LW8;
    GHOST.v = 1'b0;
    tbl[0] = row(ADD3, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[1] = row(SUB4, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[2] = row(NOP, 2'b00, 2'd2, 2'd0, 4'b1100, 0);
    tbl[3] = row(ADD3, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[4] = row(NOP, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[5] = row(SUB4, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[6] = row(NOP, 2'b00, 2'd1, 2'd0, 4'b1100, 0);
    tbl[7] = row(A7, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[8] = row(B7, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[9] = row(C9, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[10] = row(NOP, 2'b00, 2'd0, 2'd2, 4'b1100, 0);
    tbl[11] = row(D0, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[12] = row(E0, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[13] = row(F5, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[14] = row(NOP, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[15] = row(LW8, 2'b00, 2'd0, 2'd0, 4'b1100, 0);
    tbl[16] = row(ADD10, 2'b00, 2'd0, 2'd0, 4'b0010, 0);
    tbl[17] = row(ADD10, 2'b00, 2'd0, 2'd0, 4'b1100, 1);
    tbl[18] = row(NOP, 2'b00, 2'd1, 2'd1, 4'b1100, 1);
    tbl[19] = row(LW8, 2'b00, 2'd0, 2'd0, 4'b1100, 1);
    tbl[20] = row(ADD10, 2'b10, 2'd0, 2'd0, 4'b1101, 1);
    tbl[21] = row(NOP, 2'b00, 2'd0, 2'd0, 4'b1100, 1);
    tbl[22] = row(ADD3, 2'b00, 2'd0, 2'd0, 4'b1100, 1);
    tbl[23] = row(SUB4, 2'b00, 2'd0, 2'd0, 4'b1100, 1);
    tbl[24] = row(NOP, 2'b01, 2'd2, 2'd0, 4'b0000, 1);
    tbl[25] = row(NOP, 2'b11, 2'd2, 2'd0, 4'b0000, 2);
    tbl[26] = row(NOP, 2'b01, 2'd2, 2'd0, 4'b0000, 3);
    tbl[27] = row(NOP, 2'b00, 2'd2, 2'd0, 4'b1100, 4);
    tbl[28] = row(NOP, 2'b00, 2'd0, 2'd0, 4'b1100, 4);
    tbl[29] = row(LW8, 2'b00, 2'd0, 2'd0, 4'b1100, 4);
    tbl[30] = row(ADD10, 2'b01, 2'd0, 2'd0, 4'b0000, 4);
    tbl[31] = row(ADD10, 2'b00, 2'd0, 2'd0, 4'b0010, 5);
    tbl[32] = row(ADD10, 2'b00, 2'd0, 2'd0, 4'b1100, 6);
    tbl[33] = row(NOP, 2'b00, 2'd1, 2'd1, 4'b1100, 6);
    tbl[34] = row(LW8, 2'b00, 2'd0, 2'd0, 4'b1100, 6);
    tbl[35] = row(ADDI8, 2'b00, 2'd0, 2'd0, 4'b1100, 6);
    tbl[36] = row(NOP, 2'b00, 2'd0, 2'd2, 4'b1100, 6);
    tbl[37] = row(GHOST, 2'b00, 2'd0, 2'd0, 4'b1100, 6);
    tbl[38] = row(ADD10, 2'b00, 2'd0, 2'd0, 4'b1100, 6);

    drive(NOP, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all("reset", 2'd0, 2'd0, 4'b1100, 0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k].i, tbl[k].ctl[1], tbl[k].ctl[0]);
      #1;
      check_all($sformatf("vec%0d", k), tbl[k].fa, tbl[k].fb, tbl[k].fl, tbl[k].cnt);
    end

    @(negedge clk);
    drive(LW8, 1'b0, 1'b0);
    @(negedge clk);
    drive(ADD10, 1'b0, 1'b0);
    #1;
    check_all("lu before reset", 2'd0, 2'd0, 4'b0010, 6);
    rst_n = 1'b0;
    #1;
    check_all("async reset mid stall", 2'd0, 2'd0, 4'b1100, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("after reset release", 2'd0, 2'd0, 4'b1100, 0);

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(NOP, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(NOP, 1'b0, 1'b0);
    #1;
    chk("stall_cnt saturation", stall_cnt, 7);
    chk("pc_write after freeze", pc_write, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
